// File: rtl/sort_ui_pkg.sv
// Shared encodings and speed-level limits for the sorting-screen UI blocks.
package sort_ui_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_FINISHED  = 2'd3
  } sched_state_e;

  localparam logic [1:0] SPEED_MIN   = 2'd0;
  localparam logic [1:0] SPEED_MAX   = 2'd3;
  localparam logic [1:0] SPEED_RESET = 2'd1;

endpackage

// File: rtl/step_tick_timer.sv
// Auto-step tick counter; period is BASE_PERIOD shifted right by the speed level.
module step_tick_timer #(
  parameter int unsigned BASE_PERIOD = 200_000_000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       count_en_i,
  input  logic [1:0] speed_level_i,
  output logic       tick_o
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d, period;

  always_comb begin
    period = BASE >> speed_level_i;
    tick_o = count_en_i && (cnt_q == period - CNT_W'(1));
    cnt_d  = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/auto_step_scheduler.sv
// Play/pause/step scheduler for the education sorting screen; all pulse outputs registered.
module auto_step_scheduler
  import sort_ui_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 200_000_000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       enable,
  input  logic       play_toggle_pulse,
  input  logic       speed_up_pulse,
  input  logic       speed_down_pulse,
  input  logic       manual_next_req,
  input  logic       manual_prev_req,
  input  logic       is_sorted,
  input  logic       is_at_start,
  input  logic       engine_busy,
  output logic       step_next,
  output logic       step_prev,
  output logic       playing,
  output logic [1:0] speed_level,
  output logic       auto_done
);

  sched_state_e state_q, state_d;
  logic         wait_first_q, wait_first_d;
  logic [1:0]   speed_q, speed_d;
  logic         step_next_q, step_next_d;
  logic         step_prev_q, step_prev_d;
  logic         auto_done_q, auto_done_d;
  logic         tick, timer_en, timer_clear, speed_changed;
  logic         any_req, can_next, can_prev;

  step_tick_timer #(
    .BASE_PERIOD(BASE_PERIOD),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk_100mhz   (clk_100mhz),
    .reset        (reset),
    .clear_i      (timer_clear),
    .count_en_i   (timer_en),
    .speed_level_i(speed_q),
    .tick_o       (tick)
  );

  always_comb begin
    state_d       = state_q;
    wait_first_d  = 1'b0;
    speed_d       = speed_q;
    step_next_d   = 1'b0;
    step_prev_d   = 1'b0;
    auto_done_d   = 1'b0;
    speed_changed = 1'b0;
    any_req       = play_toggle_pulse || manual_next_req || manual_prev_req;
    can_next      = !is_sorted && !engine_busy;
    can_prev      = !is_at_start && !engine_busy;
    timer_en      = enable && (state_q == ST_PLAYING) && !engine_busy;

    if (!enable) begin
      state_d = ST_PAUSED;
    end else begin
      if (speed_up_pulse && !speed_down_pulse && speed_q != SPEED_MAX) begin
        speed_d       = speed_q + 2'd1;
        speed_changed = 1'b1;
      end else if (speed_down_pulse && !speed_up_pulse && speed_q != SPEED_MIN) begin
        speed_d       = speed_q - 2'd1;
        speed_changed = 1'b1;
      end

      case (state_q)
        ST_PAUSED: begin
          if (play_toggle_pulse) begin
            if (!is_sorted) state_d = ST_PLAYING;
          end else if (manual_next_req) begin
            step_next_d = can_next;
          end else if (manual_prev_req) begin
            step_prev_d = can_prev;
          end
        end
        ST_PLAYING: begin
          if (any_req) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (is_sorted) begin
              state_d     = ST_FINISHED;
              auto_done_d = 1'b1;
            end else begin
              state_d      = ST_WAIT_BUSY;
              wait_first_d = 1'b1;
              step_next_d  = 1'b1;
            end
          end
        end
        ST_WAIT_BUSY: begin
          // busy cannot yet reflect the step just issued, so it is masked in
          // the entry cycle; the timer itself holds while busy stays high
          if (any_req) begin
            state_d = ST_PAUSED;
          end else if (wait_first_q || !engine_busy) begin
            state_d = ST_PLAYING;
          end
        end
        ST_FINISHED: begin
          if (!play_toggle_pulse && !manual_next_req && manual_prev_req && can_prev) begin
            step_prev_d = 1'b1;
            state_d     = ST_PAUSED;
          end
        end
        default: state_d = ST_PAUSED;
      endcase
    end

    timer_clear = (state_d != ST_PLAYING) || speed_changed;
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q      <= ST_PAUSED;
      wait_first_q <= 1'b0;
      speed_q      <= SPEED_RESET;
      step_next_q  <= 1'b0;
      step_prev_q  <= 1'b0;
      auto_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
      speed_q      <= speed_d;
      step_next_q  <= step_next_d;
      step_prev_q  <= step_prev_d;
      auto_done_q  <= auto_done_d;
    end
  end

  assign step_next   = step_next_q;
  assign step_prev   = step_prev_q;
  assign auto_done   = auto_done_q;
  assign speed_level = speed_q;
  assign playing     = (state_q == ST_PLAYING) || (state_q == ST_WAIT_BUSY);

endmodule

// File: tb/tb_auto_step_scheduler.sv
// Scenario bench for auto_step_scheduler with a behavioural playback model.
module tb_auto_step_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, tog, up, dn, mn, mp, srt, ats, busy;
  logic sn, sp, ply, ad;
  logic [1:0] spd;

  int errors = 0;
  int checks = 0;

  auto_step_scheduler #(
    .BASE_PERIOD(16),
    .CNT_W      (8)
  ) dut (
    .clk_100mhz       (clk),
    .reset            (rst),
    .enable           (en),
    .play_toggle_pulse(tog),
    .speed_up_pulse   (up),
    .speed_down_pulse (dn),
    .manual_next_req  (mn),
    .manual_prev_req  (mp),
    .is_sorted        (srt),
    .is_at_start      (ats),
    .engine_busy      (busy),
    .step_next        (sn),
    .step_prev        (sp),
    .playing          (ply),
    .speed_level      (spd),
    .auto_done        (ad)
  );

  // Model: mode 0 paused, 1 playing, 2 waiting for engine, 3 finished.
  // m_idle counts idle playing cycles; a step is due when it reaches the period.
  int m_mode = 0;
  int m_idle = 0;
  int m_speed = 1;
  bit m_sn = 0, m_sp = 0, m_ad = 0;

  task automatic model_edge();
    int period;
    int nspeed;
    bit req;
    if (rst) begin
      m_mode = 0; m_idle = 0; m_speed = 1; m_sn = 0; m_sp = 0; m_ad = 0;
      return;
    end
    m_sn = 0; m_sp = 0; m_ad = 0;
    if (!en) begin
      m_mode = 0; m_idle = 0;
      return;
    end
    period = 16 / (1 << m_speed);
    nspeed = m_speed;
    if (up && !dn) nspeed = (m_speed < 3) ? m_speed + 1 : 3;
    else if (dn && !up) nspeed = (m_speed > 0) ? m_speed - 1 : 0;
    req = tog || mn || mp;
    case (m_mode)
      0: begin
        if (tog) begin
          if (!srt) m_mode = 1;
        end else if (mn) m_sn = !srt && !busy;
        else if (mp) m_sp = !ats && !busy;
      end
      1: begin
        if (req) m_mode = 0;
        else if (!busy) begin
          m_idle = m_idle + 1;
          if (m_idle == period) begin
            if (srt) begin m_mode = 3; m_ad = 1; end
            else begin m_mode = 2; m_sn = 1; end
          end
        end
      end
      2: m_mode = req ? 0 : 1;
      default: begin
        if (!tog && !mn && mp && !ats && !busy) begin m_sp = 1; m_mode = 0; end
      end
    endcase
    if (m_mode != 1 || nspeed != m_speed) m_idle = 0;
    m_speed = nspeed;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    tog = 0; up = 0; dn = 0; mn = 0; mp = 0;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); cyc(); rst = 0;
    checks++; if (sn !== 1'b0) begin errors++; $display("FAIL reset_step_next: got %b expected 0", sn); end
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL reset_step_prev: got %b expected 0", sp); end
    checks++; if (ply !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b expected 0", ply); end
    checks++; if (ad !== 1'b0) begin errors++; $display("FAIL reset_auto_done: got %b expected 0", ad); end
    checks++; if (spd !== 2'd1) begin errors++; $display("FAIL reset_speed: got %0d expected 1", spd); end
  endtask

  task automatic test_auto_period();
    int hits[$];
    tog = 1; cyc();
    checks++; if (ply !== 1'b1) begin errors++; $display("FAIL play_enter: got %b expected 1", ply); end
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (sn === 1'b1) hits.push_back(i);
    end
    checks++;
    if (hits.size() != 3) begin
      errors++; $display("FAIL auto_step_count: got %0d expected 3", hits.size());
    end else begin
      checks++; if (hits[0] != 8) begin errors++; $display("FAIL first_step: got cycle %0d expected 8", hits[0]); end
      checks++; if (hits[1] - hits[0] != 9) begin errors++; $display("FAIL step_gap1: got %0d expected 9", hits[1] - hits[0]); end
      checks++; if (hits[2] - hits[1] != 9) begin errors++; $display("FAIL step_gap2: got %0d expected 9", hits[2] - hits[1]); end
    end
  endtask

  task automatic test_busy_hold();
    int k = 0;
    bit seen = 0;
    while (sn !== 1'b1 && k < 20) begin cyc(); k++; end
    checks++; if (sn !== 1'b1) begin errors++; $display("FAIL busy_sync_step: got %b expected 1", sn); end
    busy = 1;
    for (int i = 0; i < 20; i++) begin cyc(); if (sn === 1'b1) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL busy_no_step: got 1 expected 0"); end
    checks++; if (ply !== 1'b1) begin errors++; $display("FAIL busy_playing: got %b expected 1", ply); end
    busy = 0; k = 0;
    do begin cyc(); k++; end while (sn !== 1'b1 && k < 30);
    checks++; if (k != 8) begin errors++; $display("FAIL busy_release_gap: got %0d expected 8", k); end
  endtask

  task automatic test_speed();
    int k;
    tog = 1; cyc();
    checks++; if (ply !== 1'b0) begin errors++; $display("FAIL pause_from_wait: got %b expected 0", ply); end
    repeat (3) begin up = 1; cyc(); end
    checks++; if (spd !== 2'd3) begin errors++; $display("FAIL speed_sat_hi: got %0d expected 3", spd); end
    tog = 1; cyc(); k = 0;
    do begin cyc(); k++; end while (sn !== 1'b1 && k < 40);
    checks++; if (k != 2) begin errors++; $display("FAIL period_lvl3: got %0d expected 2", k); end
    tog = 1; cyc();
    repeat (5) begin dn = 1; cyc(); end
    checks++; if (spd !== 2'd0) begin errors++; $display("FAIL speed_sat_lo: got %0d expected 0", spd); end
    tog = 1; cyc(); k = 0;
    do begin cyc(); k++; end while (sn !== 1'b1 && k < 40);
    checks++; if (k != 16) begin errors++; $display("FAIL period_lvl0: got %0d expected 16", k); end
    tog = 1; cyc();
    repeat (3) begin up = 1; cyc(); end
    up = 1; dn = 1; cyc();
    checks++; if (spd !== 2'd3) begin errors++; $display("FAIL speed_up_down: got %0d expected 3", spd); end
  endtask

  task automatic test_sorted_finish();
    int k = 0;
    bit stepped = 0;
    tog = 1; cyc();
    srt = 1;
    do begin cyc(); k++; if (sn === 1'b1) stepped = 1; end while (ad !== 1'b1 && k < 10);
    checks++; if (k != 2) begin errors++; $display("FAIL done_delay: got %0d expected 2", k); end
    checks++; if (stepped) begin errors++; $display("FAIL done_no_step: got 1 expected 0"); end
    checks++; if (ply !== 1'b0) begin errors++; $display("FAIL done_playing: got %b expected 0", ply); end
    cyc();
    checks++; if (ad !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", ad); end
    tog = 1; cyc(); cyc();
    checks++; if (ply !== 1'b0) begin errors++; $display("FAIL finished_toggle: got %b expected 0", ply); end
    mn = 1; cyc(); cyc();
    checks++; if (sn !== 1'b0) begin errors++; $display("FAIL finished_next: got %b expected 0", sn); end
    ats = 0; mp = 1; cyc();
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL finished_prev: got %b expected 1", sp); end
    cyc();
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL prev_width: got %b expected 0", sp); end
    srt = 0;
  endtask

  task automatic test_priority();
    tog = 1; mn = 1; cyc();
    checks++; if (ply !== 1'b1 || sn !== 1'b0) begin errors++; $display("FAIL toggle_over_next: got playing=%b step=%b expected 1 0", ply, sn); end
    tog = 1; cyc();
    ats = 1; mp = 1; cyc();
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL prev_at_start: got %b expected 0", sp); end
    ats = 0; mp = 1; cyc();
    checks++; if (sp !== 1'b1 || sn !== 1'b0) begin errors++; $display("FAIL manual_prev: got prev=%b next=%b expected 1 0", sp, sn); end
    mn = 1; mp = 1; cyc();
    checks++; if (sn !== 1'b1 || sp !== 1'b0) begin errors++; $display("FAIL next_over_prev: got next=%b prev=%b expected 1 0", sn, sp); end
    busy = 1; mn = 1; cyc(); busy = 0;
    checks++; if (sn !== 1'b0) begin errors++; $display("FAIL next_when_busy: got %b expected 0", sn); end
  endtask

  task automatic test_enable_reset();
    int k = 0;
    bit pulsed = 0;
    tog = 1; cyc();
    en = 0; cyc(); en = 1;
    checks++; if (ply !== 1'b0 || sn !== 1'b0 || ad !== 1'b0) begin errors++; $display("FAIL disable_pause: got playing=%b step=%b done=%b expected 0 0 0", ply, sn, ad); end
    checks++; if (spd !== 2'd3) begin errors++; $display("FAIL disable_speed: got %0d expected 3", spd); end
    for (int i = 0; i < 6; i++) begin cyc(); if (sn === 1'b1 || ply === 1'b1) pulsed = 1; end
    checks++; if (pulsed) begin errors++; $display("FAIL disable_stays_paused: got 1 expected 0"); end
    tog = 1; cyc();
    while (sn !== 1'b1 && k < 10) begin cyc(); k++; end
    rst = 1; cyc(); rst = 0;
    checks++; if (sn !== 1'b0 || sp !== 1'b0 || ad !== 1'b0 || ply !== 1'b0 || spd !== 2'd1) begin
      errors++; $display("FAIL reset_in_wait: got next=%b prev=%b done=%b play=%b spd=%0d expected 0 0 0 0 1", sn, sp, ad, ply, spd);
    end
    tog = 1; cyc();
    repeat (7) cyc();
    rst = 1; cyc(); rst = 0;
    checks++; if (sn !== 1'b0 || ply !== 1'b0) begin errors++; $display("FAIL reset_at_tick: got step=%b play=%b expected 0 0", sn, ply); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 59) != 0);
      tog  = ($urandom_range(0, 39) == 0);
      up   = ($urandom_range(0, 15) == 0);
      dn   = ($urandom_range(0, 15) == 0);
      mn   = ($urandom_range(0, 13) == 0);
      mp   = ($urandom_range(0, 13) == 0);
      busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) srt = ~srt;
      if ($urandom_range(0, 19) == 0) ats = ~ats;
      cyc();
      checks++; if (sn !== m_sn) begin errors++; $display("FAIL rnd_step_next @%0d: got %b expected %b", i, sn, m_sn); end
      checks++; if (sp !== m_sp) begin errors++; $display("FAIL rnd_step_prev @%0d: got %b expected %b", i, sp, m_sp); end
      checks++; if (ad !== m_ad) begin errors++; $display("FAIL rnd_auto_done @%0d: got %b expected %b", i, ad, m_ad); end
      checks++; if (ply !== (m_mode == 1 || m_mode == 2)) begin errors++; $display("FAIL rnd_playing @%0d: got %b expected %b", i, ply, (m_mode == 1 || m_mode == 2)); end
      checks++; if (spd !== 2'(m_speed)) begin errors++; $display("FAIL rnd_speed @%0d: got %0d expected %0d", i, spd, m_speed); end
      checks++; if (sn === 1'b1 && sp === 1'b1) begin errors++; $display("FAIL rnd_both_steps @%0d: got 1 1 expected not both", i); end
    end
    rst = 0; en = 1;
  endtask

  initial begin
    rst = 1; en = 1; tog = 0; up = 0; dn = 0; mn = 0; mp = 0;
    srt = 0; ats = 0; busy = 0;
    test_reset();
    test_auto_period();
    test_busy_hold();
    test_speed();
    test_sorted_finish();
    test_priority();
    test_enable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/auto_step_scheduler.md
AUTO_STEP_SCHEDULER -- requirements
Module: auto_step_scheduler

Interface
REQ-001 Parameter BASE_PERIOD, default 200_000_000, auto-step period in clocks at speed level 0 (2 s at 100 MHz).
REQ-002 Parameter CNT_W, default 28, tick counter width; SHALL satisfy 2^CNT_W > BASE_PERIOD.
REQ-003 clk_100mhz  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  high while the education sorting screen is active.
REQ-006 play_toggle_pulse  in  1  one-cycle toggle between play and pause.
REQ-007 speed_up_pulse, speed_down_pulse  in  1 each  one-cycle speed change requests.
REQ-008 manual_next_req, manual_prev_req  in  1 each  one-cycle manual step requests.
REQ-009 is_sorted, is_at_start  in  1 each  sort engine status flags.
REQ-010 engine_busy  in  1  high while the sort engine or display is animating a step.
REQ-011 step_next, step_prev  out  1 each  one-cycle step commands to the sort engine.
REQ-012 playing  out  1  high in PLAYING and WAIT_BUSY.
REQ-013 speed_level  out  2  current speed, 0 = slowest.
REQ-014 auto_done  out  1  one-cycle pulse when playback completes.

Function
REQ-015 States: PAUSED, PLAYING, WAIT_BUSY, FINISHED.
REQ-016 Period = BASE_PERIOD >> speed_level.
REQ-017 speed_up saturates at 3 and speed_down saturates at 0; any accepted change clears the tick counter; simultaneous up and down = no change.
REQ-018 PAUSED + play_toggle with is_sorted=0 -> PLAYING with counter=0; with is_sorted=1 the toggle is ignored.
REQ-019 PLAYING: the counter increments only while engine_busy=0. When counter == Period-1 and is_sorted=0, step_next=1 that cycle, counter clears, -> WAIT_BUSY.
REQ-020 PLAYING with is_sorted=1 at tick -> FINISHED, auto_done=1 that cycle, no step issued.
REQ-021 WAIT_BUSY: engine_busy is ignored in the first cycle after entry; thereafter, once engine_busy=0 -> PLAYING.
REQ-022 PLAYING/WAIT_BUSY + play_toggle -> PAUSED, counter cleared; a step already issued is not retracted.
REQ-023 Manual requests in PLAYING/WAIT_BUSY: pause playback and are dropped (no step issued).
REQ-024 PAUSED: manual_next_req with is_sorted=0 and engine_busy=0 -> step_next next cycle. manual_prev_req with is_at_start=0 and engine_busy=0 -> step_prev next cycle. Otherwise the request is dropped.
REQ-025 Priority when several inputs are active in one cycle: play_toggle > manual_next_req > manual_prev_req; lower-priority requests are dropped.
REQ-026 FINISHED: manual_prev_req (same conditions as REQ-024) issues step_prev and -> PAUSED. play_toggle and manual_next_req are ignored.
REQ-027 step_next and step_prev SHALL never both be high; each is exactly one cycle wide.
REQ-028 enable=0: any state -> PAUSED next cycle, counter cleared, all pulse outputs 0, speed_level retained.

Reset
REQ-029 On reset: state=PAUSED, counter=0, speed_level=1, step_next=0, step_prev=0, playing=0, auto_done=0.
REQ-030 Reset mid-WAIT_BUSY or mid-count SHALL abandon the step sequence without emitting a pulse in the reset cycle.

Structure
REQ-031 State encodings and speed-level limits live in shared package sort_ui_pkg; BASE_PERIOD stays a module parameter.
REQ-032 One sub-module, step_tick_timer: counter, period shift, clear and enable. The FSM and arbitration stay in the top module.

Verification (BASE_PERIOD=16, so periods are 16/8/4/2)
REQ-033 Reset, speed 1, play_toggle, busy=0 -> first step_next exactly 8 cycles after entering PLAYING, then every 8 cycles plus one WAIT_BUSY cycle.
REQ-034 While playing, engine_busy held high 20 cycles after a step -> no further step until 8 counted idle cycles after busy falls.
REQ-035 speed_up x3 from level 1 -> speed_level=3, not 4; period 2. speed_down x5 -> speed_level=0; period 16.
REQ-036 Playing, is_sorted rises -> auto_done one pulse at the next tick, playing=0, state FINISHED; a later play_toggle has no effect.
REQ-037 PAUSED, play_toggle and manual_next_req in the same cycle -> PLAYING, no step_next; manual_prev_req with is_at_start=1 -> no step_prev.
REQ-038 Playing mid-count, enable=0 for 1 cycle -> PAUSED, no pulses; reset during WAIT_BUSY -> all outputs at reset values.
